traffic_monitor: RTL

- Passive checker on the far end of the traffic controller's output interface.
- Observes the six lamp signals and the two 7-segment countdown codes.
- Decodes the segment codes back to a timer value and tracks the phase sequence.
- Flags illegal lamp patterns, out-of-order phases, wrong dwell times and bad countdowns; used in the system bench and as an on-chip safety monitor.

---
 rtl/traffic_pkg.sv | 31 +++
 rtl/seven_segment_decoder.sv | 32 +++
 rtl/traffic_monitor.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller output monitor.
// Contents: phase encodings, default phase countdown times, and the
// seven-segment codes for digits 0..9 (segment order g..a in bits 6..0,
// bit 7 is the decimal point and is always off).
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_A_GREEN  = 2'd0,
    PH_A_YELLOW = 2'd1,
    PH_B_GREEN  = 2'd2,
    PH_B_YELLOW = 2'd3
  } phase_e;

  localparam int DEF_A_GREEN_TIME  = 15;
  localparam int DEF_A_YELLOW_TIME = 5;
  localparam int DEF_B_GREEN_TIME  = 15;
  localparam int DEF_B_YELLOW_TIME = 5;
  localparam int DEF_CNT_W         = 8;

  localparam logic [7:0] SEG_0 = 8'h3f;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5b;
  localparam logic [7:0] SEG_3 = 8'h4f;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6d;
  localparam logic [7:0] SEG_6 = 8'h7d;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7f;
  localparam logic [7:0] SEG_9 = 8'h6f;

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational seven-segment to BCD decoder.
// Ports:
//   code  - 8-bit segment code as driven to the display
//   digit - decoded value 0..9 (0 when the code is not recognised)
//   valid - 1 when code is one of the ten digit patterns
module seven_segment_decoder
  import traffic_pkg::*;
(
  input  logic [7:0] code,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (code)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_monitor.sv
// Passive checker for the traffic controller output interface.
// Stage 1 samples the lamps and segment codes; stage 2 compares that sample
// with the previous one and registers every output (2-edge latency).
// Ports:
//   clk, reset (async, active-low)
//   A_green/A_yellow/A_red, B_green/B_yellow/B_red - observed lamps
//   seg_tens, seg_ones - observed countdown digits
//   clr           - synchronous clear of err_count / err_sticky (beats errors)
//   phase, phase_valid, decoded_timer - decoded view of the interface
//   err_conflict/sequence/dwell/timer/segment - one-cycle error pulses
//   err_count     - saturating count of cycles with any error
//   err_sticky    - latched {segment,timer,dwell,sequence,conflict}; only
//                   implemented when TRAFFIC_MONITOR_STICKY_EN is defined,
//                   otherwise tied to zero.
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int A_GREEN_TIME  = DEF_A_GREEN_TIME,
  parameter int A_YELLOW_TIME = DEF_A_YELLOW_TIME,
  parameter int B_GREEN_TIME  = DEF_B_GREEN_TIME,
  parameter int B_YELLOW_TIME = DEF_B_YELLOW_TIME,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             A_green,
  input  logic             A_yellow,
  input  logic             A_red,
  input  logic             B_green,
  input  logic             B_yellow,
  input  logic             B_red,
  input  logic [7:0]       seg_tens,
  input  logic [7:0]       seg_ones,
  input  logic             clr,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [7:0]       decoded_timer,
  output logic             err_conflict,
  output logic             err_sequence,
  output logic             err_dwell,
  output logic             err_timer,
  output logic             err_segment,
  output logic [CNT_W-1:0] err_count,
  output logic [4:0]       err_sticky
);

  function automatic logic [7:0] phase_time(input logic [1:0] p);
    case (p)
      2'd0:    phase_time = 8'(A_GREEN_TIME);
      2'd1:    phase_time = 8'(A_YELLOW_TIME);
      2'd2:    phase_time = 8'(B_GREEN_TIME);
      default: phase_time = 8'(B_YELLOW_TIME);
    endcase
  endfunction

  // Stage 1 sample; s1_vld keeps the cleared sample from being judged.
  logic [5:0] s1_lamps;
  logic [7:0] s1_tens, s1_ones;
  logic       s1_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_lamps <= '0;
      s1_tens  <= '0;
      s1_ones  <= '0;
      s1_vld   <= 1'b0;
    end else begin
      s1_lamps <= {A_green, A_yellow, A_red, B_green, B_yellow, B_red};
      s1_tens  <= seg_tens;
      s1_ones  <= seg_ones;
      s1_vld   <= 1'b1;
    end
  end

  logic [3:0] tens_digit, ones_digit;
  logic       tens_ok, ones_ok;

  seven_segment_decoder u_dec_tens (.code(s1_tens), .digit(tens_digit), .valid(tens_ok));
  seven_segment_decoder u_dec_ones (.code(s1_ones), .digit(ones_digit), .valid(ones_ok));

  // Stage 2 history of the previous stage-1 sample. decoded_timer doubles
  // as the previous timer value: it only matters when prev_seg_ok is set.
  phase_e           prev_phase;
  logic             prev_valid;
  logic             prev_seg_ok;
  logic             resync;
  logic [CNT_W-1:0] dwell;

  phase_e           cur_phase;
  logic             cur_valid;
  logic             seg_ok;
  logic [7:0]       cur_timer;
  logic [1:0]       next_ph;
  logic [CNT_W-1:0] dwell_exp;

  assign seg_ok    = tens_ok & ones_ok;
  assign cur_timer = ({4'd0, tens_digit} * 8'd10) + {4'd0, ones_digit};
  assign next_ph   = prev_phase + 2'd1;
  assign dwell_exp = CNT_W'(phase_time(prev_phase)) + CNT_W'(1);

  always_comb begin
    cur_valid = 1'b1;
    cur_phase = PH_A_GREEN;
    case (s1_lamps)
      6'b100_001: cur_phase = PH_A_GREEN;
      6'b010_001: cur_phase = PH_A_YELLOW;
      6'b001_100: cur_phase = PH_B_GREEN;
      6'b001_010: cur_phase = PH_B_YELLOW;
      default:    cur_valid = 1'b0;
    endcase
  end

  logic             conflict_d, sequence_d, dwell_err_d, timer_d, segment_d, any_err;
  logic             resync_d;
  logic [CNT_W-1:0] dwell_d;

  always_comb begin
    conflict_d  = 1'b0;
    sequence_d  = 1'b0;
    dwell_err_d = 1'b0;
    timer_d     = 1'b0;
    segment_d   = 1'b0;
    resync_d    = resync;
    dwell_d     = dwell;
    if (s1_vld) begin
      conflict_d = !cur_valid;
      segment_d  = !seg_ok;
      if (!cur_valid) begin
        resync_d = 1'b1;
      end else if (!prev_valid) begin
        // First legal sample after reset or a conflict: accept unchecked.
        dwell_d = CNT_W'(1);
      end else if (cur_phase == prev_phase) begin
        if (dwell != '1) dwell_d = dwell + CNT_W'(1);
      end else if (cur_phase == next_ph) begin
        dwell_err_d = !resync && (dwell != dwell_exp);
        resync_d    = 1'b0;
        dwell_d     = CNT_W'(1);
      end else begin
        sequence_d = 1'b1;
        resync_d   = 1'b1;
        dwell_d    = CNT_W'(1);
      end
      if (cur_valid && prev_valid && seg_ok && prev_seg_ok) begin
        if (cur_phase == prev_phase)
          timer_d = (decoded_timer == 8'd0) || (cur_timer != decoded_timer - 8'd1);
        else
          timer_d = (cur_timer != phase_time(cur_phase));
      end
    end
    any_err = conflict_d | sequence_d | dwell_err_d | timer_d | segment_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_phase    <= PH_A_GREEN;
      prev_valid    <= 1'b0;
      prev_seg_ok   <= 1'b0;
      resync        <= 1'b1;
      dwell         <= '0;
      phase         <= 2'd0;
      phase_valid   <= 1'b0;
      decoded_timer <= 8'd0;
      err_conflict  <= 1'b0;
      err_sequence  <= 1'b0;
      err_dwell     <= 1'b0;
      err_timer     <= 1'b0;
      err_segment   <= 1'b0;
      err_count     <= '0;
    end else begin
      if (s1_vld) begin
        prev_phase  <= cur_phase;
        prev_valid  <= cur_valid;
        prev_seg_ok <= seg_ok;
        resync      <= resync_d;
        dwell       <= dwell_d;
        phase_valid <= cur_valid;
        if (cur_valid) phase <= cur_phase;
        if (seg_ok) decoded_timer <= cur_timer;
      end
      err_conflict <= conflict_d;
      err_sequence <= sequence_d;
      err_dwell    <= dwell_err_d;
      err_timer    <= timer_d;
      err_segment  <= segment_d;
      if (clr)
        err_count <= '0;
      else if (any_err && (err_count != '1))
        err_count <= err_count + CNT_W'(1);
    end
  end

`ifdef TRAFFIC_MONITOR_STICKY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_sticky <= '0;
    else if (clr)
      err_sticky <= '0;
    else
      err_sticky <= err_sticky | {segment_d, timer_d, dwell_err_d, sequence_d, conflict_d};
  end
`else
  assign err_sticky = 5'd0;
`endif

endmodule
